// File: rtl/sha_pkg.sv
// Shared SHA types, round counts, round-constant tables and bit helpers.
// SHA-1 items exist only when SHA_SCHED_SHA1_EN is defined.
package sha;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        MODE_SHA256 = 2'd0,
        MODE_SHA1   = 2'd1,
        MODE_RSVD2  = 2'd2,
        MODE_RSVD3  = 2'd3
    } mode_t;

    localparam int unsigned SHA256_ROUNDS = 64;

    localparam word_t K256 [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

`ifdef SHA_SCHED_SHA1_EN
    localparam int unsigned SHA1_ROUNDS = 80;

    localparam word_t K1 [4] = '{
        32'h5a827999, 32'h6ed9eba1, 32'h8f1bbcdc, 32'hca62c1d6
    };

    // SHA-1 round group t/20, also the K1 index
    function automatic logic [1:0] ft_of(input logic [6:0] t);
        if (t < 7'd20)      return 2'd0;
        else if (t < 7'd40) return 2'd1;
        else if (t < 7'd60) return 2'd2;
        else                return 2'd3;
    endfunction
`endif

    function automatic word_t rotl(input word_t x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return rotl(x, 32 - n);
    endfunction

    function automatic word_t sig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha_w_expand.sv
// Combinational next-W from four schedule taps.
// Taps: SHA-256 a/b/c/d = W[t-2]/W[t-7]/W[t-15]/W[t-16]; SHA-1 = W[t-3]/W[t-8]/W[t-14]/W[t-16].
module sha_w_expand
    import sha::*;
(
`ifdef SHA_SCHED_SHA1_EN
    input  sha::mode_t  mode,
`endif
    input  logic [31:0] tap_a,
    input  logic [31:0] tap_b,
    input  logic [31:0] tap_c,
    input  logic [31:0] tap_d,
    output logic [31:0] w
);

    always_comb begin
`ifdef SHA_SCHED_SHA1_EN
        if (mode == MODE_SHA1)
            w = rotl(tap_a ^ tap_b ^ tap_c ^ tap_d, 1);
        else
            w = sig1(tap_a) + tap_b + sig0(tap_c) + tap_d;
`else
        w = sig1(tap_a) + tap_b + sig0(tap_c) + tap_d;
`endif
    end

endmodule

// File: rtl/sha_msg_schedule.sv
// SHA message schedule: 16 input words in, W_t/K_t/ft per round out, 16-entry in-place expansion.
// SHA_SCHED_SHA1_EN enables SHA-1 mode (80 rounds, ft, SHA-1 K and expansion).
module sha_msg_schedule
    import sha::*;
(
    input  logic        clk,
    input  logic        rst,
    input  sha::mode_t  mode,
    input  logic        abort,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_w,
    output logic [31:0] out_k,
    output logic [1:0]  out_ft,
    output logic [6:0]  out_round,
    output logic        out_first,
    output logic        out_last,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EXPAND} state_t;

    state_t      state, state_nx;
    logic [6:0]  t, t_nx;
    word_t       wbuf [16];
    logic [3:0]  wa;
    logic        adv, emit, wr, set_err, supported;
    word_t       emit_w, exp_w, k_cur;
    word_t       tap_a, tap_b, tap_c, tap_d;
    logic [6:0]  last_idx;

    assign adv  = !out_valid || out_ready;
    assign wa   = t[3:0];
    assign busy = (state != ST_IDLE);

`ifdef SHA_SCHED_SHA1_EN
    logic       sha1_q;
    logic       cur_sha1;
    logic [1:0] ft_q;

    // In IDLE the round being emitted belongs to the block whose mode is on the port
    assign cur_sha1  = (state == ST_IDLE) ? (mode == MODE_SHA1) : sha1_q;
    assign supported = (mode == MODE_SHA256) || (mode == MODE_SHA1);
    assign k_cur     = cur_sha1 ? K1[ft_of(t)] : K256[t[5:0]];
    assign last_idx  = cur_sha1 ? 7'(SHA1_ROUNDS - 1) : 7'(SHA256_ROUNDS - 1);
    assign tap_a     = cur_sha1 ? wbuf[wa - 4'd3]  : wbuf[wa - 4'd2];
    assign tap_b     = cur_sha1 ? wbuf[wa - 4'd8]  : wbuf[wa - 4'd7];
    assign tap_c     = cur_sha1 ? wbuf[wa - 4'd14] : wbuf[wa - 4'd15];
    assign tap_d     = wbuf[wa];
    assign out_ft    = ft_q;

    sha_w_expand u_expand (
        .mode  (cur_sha1 ? MODE_SHA1 : MODE_SHA256),
        .tap_a (tap_a),
        .tap_b (tap_b),
        .tap_c (tap_c),
        .tap_d (tap_d),
        .w     (exp_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sha1_q <= 1'b0;
            ft_q   <= '0;
        end else begin
            if (state == ST_IDLE && emit)
                sha1_q <= cur_sha1;
            if (emit)
                ft_q <= cur_sha1 ? ft_of(t) : 2'd0;
        end
    end
`else
    assign supported = (mode == MODE_SHA256);
    assign k_cur     = K256[t[5:0]];
    assign last_idx  = 7'(SHA256_ROUNDS - 1);
    assign tap_a     = wbuf[wa - 4'd2];
    assign tap_b     = wbuf[wa - 4'd7];
    assign tap_c     = wbuf[wa - 4'd15];
    assign tap_d     = wbuf[wa];
    assign out_ft    = 2'b00;

    sha_w_expand u_expand (
        .tap_a (tap_a),
        .tap_b (tap_b),
        .tap_c (tap_c),
        .tap_d (tap_d),
        .w     (exp_w)
    );
`endif

    // t is 0 whenever IDLE, so it is always the index of the round emitted next.
    // IDLE uses adv for in_ready so an unconsumed final round is never overwritten.
    always_comb begin
        state_nx = state;
        t_nx     = t;
        in_ready = 1'b0;
        emit     = 1'b0;
        wr       = 1'b0;
        set_err  = 1'b0;
        emit_w   = in_word;
        if (abort) begin
            state_nx = ST_IDLE;
            t_nx     = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    in_ready = adv;
                    if (in_valid && adv) begin
                        if (supported) begin
                            emit     = 1'b1;
                            wr       = 1'b1;
                            t_nx     = 7'd1;
                            state_nx = ST_LOAD;
                        end else begin
                            set_err = 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    in_ready = adv;
                    if (in_valid && adv) begin
                        emit = 1'b1;
                        wr   = 1'b1;
                        t_nx = t + 7'd1;
                        if (t == 7'd15)
                            state_nx = ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    if (adv) begin
                        emit   = 1'b1;
                        wr     = 1'b1;
                        emit_w = exp_w;
                        if (t == last_idx) begin
                            t_nx     = '0;
                            state_nx = ST_IDLE;
                        end else begin
                            t_nx = t + 7'd1;
                        end
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            t         <= '0;
            out_valid <= 1'b0;
            out_w     <= '0;
            out_k     <= '0;
            out_round <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_nx;
            t     <= t_nx;
            if (abort) begin
                out_valid <= 1'b0;
                err       <= 1'b0;
            end else begin
                if (set_err)
                    err <= 1'b1;
                if (adv)
                    out_valid <= emit;
                if (emit) begin
                    out_w     <= emit_w;
                    out_k     <= k_cur;
                    out_round <= t;
                    out_first <= (t == 7'd0);
                    out_last  <= (t == last_idx);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr)
            wbuf[wa] <= emit_w;
    end

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Bench for sha_msg_schedule: spot-value table plus random blocks against a full-array schedule model.
// SHA-1 scenarios run when SHA_SCHED_SHA1_EN is defined; otherwise SHA-1 requests must raise err.
module tb_sha_msg_schedule;
    import sha::*;

    logic        clk = 1'b0;
    logic        rst, abort, in_valid, in_ready, out_valid, out_ready;
    logic        out_first, out_last, busy, err;
    mode_t       mode;
    logic [31:0] in_word, out_w, out_k;
    logic [1:0]  out_ft;
    logic [6:0]  out_round;

    always #5 clk = ~clk;

    sha_msg_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_w     (out_w),
        .out_k     (out_k),
        .out_ft    (out_ft),
        .out_round (out_round),
        .out_first (out_first),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    localparam logic [31:0] REF_K256 [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] REF_K1 [4] = '{32'h5a827999, 32'h6ed9eba1, 32'h8f1bbcdc, 32'hca62c1d6};

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    typedef struct {
        logic [31:0] w;
        logic [31:0] k;
        logic [1:0]  ft;
        logic [6:0]  r;
        logic        first;
        logic        last;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] in_q [$];
    mode_t       mq [$];
    logic [31:0] cap_w [80];
    logic [31:0] cap_k [80];
    logic [1:0]  cap_ft [80];
    logic        cap_last [80];
    int          gaps;

    // Reference: whole schedule in a flat array straight from the recurrences
    task automatic add_block(input logic [31:0] blk [16], input logic sha1);
        logic [31:0] w [80];
        int n;
        exp_t e;
        n = sha1 ? 80 : 64;
        for (int t = 0; t < n; t++) begin
            if (t < 16)
                w[t] = blk[t];
            else if (sha1) begin
                w[t] = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
                w[t] = {w[t][30:0], w[t][31]};
            end else
                w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
            e.w = w[t];
            if (sha1) begin
                e.k  = REF_K1[t / 20];
                e.ft = 2'(t / 20);
            end else begin
                e.k  = REF_K256[t];
                e.ft = 2'd0;
            end
            e.r     = 7'(t);
            e.first = (t == 0);
            e.last  = (t == n - 1);
            exp_q.push_back(e);
        end
        for (int i = 0; i < 16; i++) begin
            in_q.push_back(blk[i]);
            mq.push_back(sha1 ? MODE_SHA1 : MODE_SHA256);
        end
    endtask

    task automatic run(input int unsigned rdy_pct, input string tag);
        int cyc;
        bit seen, stall;
        logic [75:0] snap, cur;
        exp_t e;
        cyc = 0; seen = 0; stall = 0; gaps = 0; snap = '0;
        while (exp_q.size() > 0 && cyc < 4000) begin
            @(negedge clk);
            in_valid = (in_q.size() > 0);
            if (in_valid) begin
                in_word = in_q[0];
                mode    = mq[0];
            end
            out_ready = ($urandom_range(99) < rdy_pct);
            #1;
            cur = {out_w, out_k, out_ft, out_round, out_first, out_last, out_valid};
            if (stall)
                chk($sformatf("%s hold r%0d", tag, out_round), cur, snap);
            if (out_valid) seen = 1;
            else if (seen) gaps++;
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                chk($sformatf("%s w[%0d]", tag, e.r), out_w, e.w);
                chk($sformatf("%s k[%0d]", tag, e.r), out_k, e.k);
                chk($sformatf("%s ft/round/first/last @%0d", tag, e.r),
                    {out_ft, out_round, out_first, out_last}, {e.ft, e.r, e.first, e.last});
                if (out_round < 7'd80) begin
                    cap_w[out_round]    = out_w;
                    cap_k[out_round]    = out_k;
                    cap_ft[out_round]   = out_ft;
                    cap_last[out_round] = out_last;
                end
            end
            if (in_valid && in_ready) begin
                void'(in_q.pop_front());
                void'(mq.pop_front());
            end
            stall = out_valid && !out_ready;
            snap  = cur;
            cyc++;
        end
        if (exp_q.size() > 0) begin
            chk({tag, " timeout, rounds left"}, exp_q.size(), 0);
            exp_q.delete(); in_q.delete(); mq.delete();
        end
        @(negedge clk);
        in_valid  = 0;
        out_ready = 1;
        #1;
        chk({tag, " drained out_valid"}, out_valid, 0);
        chk({tag, " drained busy"}, busy, 0);
    endtask

    typedef struct {
        logic        sha1;
        int          r;
        logic [31:0] w;
        logic        use_w;
        logic [31:0] k;
        logic [1:0]  ft;
        logic        last;
    } spot_t;

    spot_t spots [9];

    task automatic check_spots(input logic sha1, input string tag);
        for (int i = 0; i < 9; i++) begin
            if (spots[i].sha1 == sha1) begin
                if (spots[i].use_w)
                    chk($sformatf("%s spot w[%0d]", tag, spots[i].r), cap_w[spots[i].r], spots[i].w);
                chk($sformatf("%s spot k[%0d]", tag, spots[i].r), cap_k[spots[i].r], spots[i].k);
                chk($sformatf("%s spot ft[%0d]", tag, spots[i].r), cap_ft[spots[i].r], spots[i].ft);
                chk($sformatf("%s spot last[%0d]", tag, spots[i].r), cap_last[spots[i].r], spots[i].last);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " out_w"}, out_w, 0);
        chk({tag, " out_k"}, out_k, 0);
        chk({tag, " out_ft"}, out_ft, 0);
        chk({tag, " out_round"}, out_round, 0);
        chk({tag, " first/last"}, {out_first, out_last}, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " err"}, err, 0);
    endtask

    logic [31:0] abc [16];
    logic [31:0] blk [16];
    mode_t       bad_modes [2];

    initial begin
        spots[0] = '{1'b0,  0, 32'h61626380, 1'b1, 32'h428a2f98, 2'd0, 1'b0};
        spots[1] = '{1'b0, 15, 32'h00000018, 1'b1, 32'hc19bf174, 2'd0, 1'b0};
        spots[2] = '{1'b0, 16, 32'h61626380, 1'b1, 32'he49b69c1, 2'd0, 1'b0};
        spots[3] = '{1'b0, 17, 32'h000f0000, 1'b1, 32'hefbe4786, 2'd0, 1'b0};
        spots[4] = '{1'b0, 63, 32'h00000000, 1'b0, 32'hc67178f2, 2'd0, 1'b1};
        spots[5] = '{1'b1,  0, 32'h61626380, 1'b1, 32'h5a827999, 2'd0, 1'b0};
        spots[6] = '{1'b1, 16, 32'hc2c4c700, 1'b1, 32'h5a827999, 2'd0, 1'b0};
        spots[7] = '{1'b1, 20, 32'h00000000, 1'b0, 32'h6ed9eba1, 2'd1, 1'b0};
        spots[8] = '{1'b1, 79, 32'h00000000, 1'b0, 32'hca62c1d6, 2'd3, 1'b1};
        for (int i = 0; i < 16; i++) abc[i] = '0;
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;

        rst = 1; abort = 0; in_valid = 0; in_word = '0; out_ready = 1; mode = MODE_SHA256;
        repeat (2) @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 0;

        add_block(abc, 1'b0);
        run(100, "abc256");
        chk("abc256 gaps", gaps, 0);
        check_spots(1'b0, "abc256");

`ifdef SHA_SCHED_SHA1_EN
        add_block(abc, 1'b1);
        run(100, "abc1");
        chk("abc1 gaps", gaps, 0);
        check_spots(1'b1, "abc1");
`endif

        add_block(abc, 1'b0);
        run(50, "bp256");
        check_spots(1'b0, "bp256");

        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 16; i++) blk[i] = $urandom;
`ifdef SHA_SCHED_SHA1_EN
            add_block(blk, b == 1);
`else
            add_block(blk, 1'b0);
`endif
        end
        run(100, "b2b");
        chk("b2b gaps", gaps, 0);

        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 16; i++) blk[i] = $urandom;
`ifdef SHA_SCHED_SHA1_EN
            add_block(blk, 1'($urandom_range(1)));
`else
            add_block(blk, 1'b0);
`endif
        end
        run(50, "rnd");

        // abort at t=30, with a word offered in the same cycle
        begin
            int idx, cyc;
            bit hit;
            idx = 0; cyc = 0; hit = 0;
            while (!hit && cyc < 300) begin
                @(negedge clk);
                in_valid  = (idx < 16);
                if (idx < 16) in_word = abc[idx];
                mode      = MODE_SHA256;
                out_ready = 1;
                #1;
                if (out_valid && out_round == 7'd30) hit = 1;
                else begin
                    if (in_valid && in_ready) idx++;
                    cyc++;
                end
            end
            chk("abort reached t30", hit, 1);
            abort    = 1;
            in_valid = 1;
            in_word  = 32'hdeadbeef;
            #1;
            chk("abort in_ready", in_ready, 0);
            @(posedge clk);
            #1;
            abort    = 0;
            in_valid = 0;
            chk("abort out_valid next", out_valid, 0);
            chk("abort busy", busy, 0);
            @(negedge clk);
            #1;
            chk("abort word dropped", out_valid, 0);
            for (int i = 0; i < 16; i++) blk[i] = $urandom;
            add_block(blk, 1'b0);
            run(100, "post-abort");
        end

        // unsupported mode: dropped, sticky err, cleared by abort
`ifdef SHA_SCHED_SHA1_EN
        bad_modes[0] = MODE_RSVD2;
`else
        bad_modes[0] = MODE_SHA1;
`endif
        bad_modes[1] = MODE_RSVD3;
        for (int m = 0; m < 2; m++) begin
            @(negedge clk);
            in_valid = 1; in_word = $urandom; mode = bad_modes[m]; out_ready = 1;
            #1;
            chk($sformatf("bad%0d in_ready", m), in_ready, 1);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                #1;
                chk($sformatf("bad%0d err c%0d", m, c), err, 1);
                chk($sformatf("bad%0d out_valid c%0d", m, c), out_valid, 0);
                chk($sformatf("bad%0d in_ready/busy c%0d", m, c), {in_ready, busy}, 2'b10);
            end
            in_valid = 0;
            @(negedge clk);
            #1;
            chk($sformatf("bad%0d err sticky", m), err, 1);
            abort = 1;
            @(negedge clk);
            abort = 0;
            #1;
            chk($sformatf("bad%0d err cleared", m), err, 0);
        end
        mode = MODE_SHA256;

        // asynchronous reset in the middle of LOAD
        begin
            int idx, cyc;
            idx = 0; cyc = 0;
            while (idx < 5 && cyc < 50) begin
                @(negedge clk);
                in_valid = 1; in_word = $urandom; mode = MODE_SHA256; out_ready = 1;
                #1;
                if (in_ready) idx++;
                cyc++;
            end
            @(negedge clk);
            in_valid = 0;
            #1;
            chk("pre-rst busy/valid", {busy, out_valid}, 2'b11);
            rst = 1;
            #1;
            check_zero("mid-load rst");
            @(negedge clk);
            rst = 0;
            for (int i = 0; i < 16; i++) blk[i] = $urandom;
            add_block(blk, 1'b0);
            run(100, "post-rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
